// File: rtl/pipeline_run_ctrl.sv
// Run controller for a pipelined core: sequences the core reset, counts cycles
// and retired instructions while running, and latches a pass/fail verdict from
// a tohost store or a cycle-budget timeout.
module pipeline_run_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RESET_CYCLES = 1,
  parameter int unsigned     MAX_CYCLES   = 5,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_1000),
  parameter logic [XLEN-1:0] PASS_CODE    = XLEN'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             retire_valid,
  input  logic             mem_wr_en,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  result,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              tohost_hit;

  assign tohost_hit = mem_wr_en && (mem_addr == TOHOST_ADDR);

  // Next-state, counter and verdict logic; outputs are derived from the next state
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          hold_d    = HOLD_INIT;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          result_d  = '0;
          cycle_d   = '0;
          instret_d = '0;
        end
      end
      ST_RESET: begin
        if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (retire_valid && (instret_q != '1)) begin
          instret_d = instret_q + CNT_W'(1);
        end
        // A tohost store takes priority over an expiring budget
        if (tohost_hit) begin
          state_d  = ST_DONE;
          result_d = mem_wdata;
          if (mem_wdata == PASS_CODE) begin
            pass_d = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
        end else if (cycle_q == LAST_CYCLE) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          result_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_rst_d = (state_d == ST_RUN);
    running_d  = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      core_rst_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      result_q   <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      result_q   <= result_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign result      = result_q;
  assign cycle_count = cycle_q;
  assign instret     = instret_q;

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

- Synthesizable run controller that sits beside `Pipeline_top` in simulation harnesses and FPGA bring-up.
- Sequences the core's reset for a parametrised number of cycles, then lets the core run.
- Counts cycles and retired instructions while the core runs.
- Ends the run on a store to a "tohost" address or on a cycle-budget timeout, and reports a latched pass/fail result.
- Replaces the fixed-delay reset and `$finish` timing of the bench with a parametrised, self-checking mechanism.

## Interface

- `XLEN`, 32: data/address width of the monitored store bus.
- `CNT_W`, 32: width of the cycle and instret counters.
- `RESET_CYCLES`, 1: cycles `core_rst` is held low after `start`; must be ≥1.
- `MAX_CYCLES`, 5: cycle budget for the RUN state; must be ≥1 and < 2^CNT_W.
- `TOHOST_ADDR`, 32'h0000_1000: store address that terminates the run.
- `PASS_CODE`, 1: `mem_wdata` value that signals pass.

Ports:

- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request to begin a run; level-sampled.
- `retire_valid` in 1: one instruction retired in this cycle.
- `mem_wr_en` in 1: core data-memory write strobe.
- `mem_addr` in XLEN: core data-memory address.
- `mem_wdata` in XLEN: core data-memory write data.
- `core_rst` out 1: active-low reset to `Pipeline_top`; registered.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE; sticky.
- `pass` out 1: run ended with tohost == PASS_CODE; sticky.
- `fail` out 1: run ended with another tohost value or by timeout; sticky.
- `timeout` out 1: run ended by cycle budget; sticky.
- `result` out XLEN: latched tohost data; 0 on timeout.
- `cycle_count` out CNT_W: RUN cycles elapsed.
- `instret` out CNT_W: retired instructions during RUN; saturates at all-ones.

## Operation

- FSM states: IDLE, RESET, RUN, DONE, all registered.
- IDLE
  - `core_rst`=0.
  - On `start`=1: go to RESET, load the hold counter with RESET_CYCLES-1, clear both counters and all result flags.
- RESET
  - `core_rst`=0.
  - Decrement the hold counter; when it is 0, go to RUN.
- RUN
  - `core_rst`=1.
  - `cycle_count` += 1 every edge.
  - `instret` += 1 on each edge where `retire_valid`=1, saturating.
  - Tohost hit is `mem_wr_en` && `mem_addr`==TOHOST_ADDR. On a hit: go to DONE, `result`=`mem_wdata`, then `pass`=1 if `mem_wdata`==PASS_CODE, else `fail`=1.
  - With no hit and `cycle_count`==MAX_CYCLES-1: go to DONE with `timeout`=1, `fail`=1, `result`=0.
  - A tohost hit and timeout on the same edge: the tohost hit wins and `timeout` stays 0.
  - `start` is ignored.
- DONE
  - `core_rst`=0, which freezes the core.
  - Counters and flags hold.
  - `start`=1 restarts exactly as from IDLE, including the clears.
- Full-width compare is used on `mem_addr`; there is no byte masking.
- `pass` and `fail` are mutually exclusive; `timeout` implies `fail`.

## Timing

- Reset (`rst`=0, asynchronous, effective at any time including mid-run):
  - State goes to IDLE.
  - `core_rst`=0.
  - `running`, `done`, `pass`, `fail`, `timeout`=0.
  - `result`, `cycle_count`, `instret`=0.
- `start` sampled high at edge E → state=RESET after E, with `core_rst` low.
- `core_rst` rises after edge E+RESET_CYCLES and `running`=1 from then on.
- Counters include the terminating edge: on a timeout, `cycle_count`=MAX_CYCLES when `done` rises.
- A tohost hit on the k-th RUN edge leaves `cycle_count`=k.
- A retire on the terminating edge is counted.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Assert `rst`=0 mid-RUN with counters nonzero → all outputs 0 immediately (asynchronously), state IDLE, `core_rst`=0.
- RESET_CYCLES=2, MAX_CYCLES=5, `start` pulse at edge 1 → `core_rst` low after edges 1–2, high after edge 3; `done`=`timeout`=`fail`=1 and `cycle_count`=5 after edge 8; `pass`=0, `result`=0.
- In RUN, `retire_valid`=1 for 3 cycles, then a store to 32'h0000_1000 with data 1 on the 4th RUN edge → `pass`=1, `fail`=0, `result`=1, `cycle_count`=4, `instret`=3.
- Store to 32'h0000_1000 with data 32'hDEAD_0003 → `fail`=1, `pass`=0, `timeout`=0, `result`=32'hDEAD_0003.
- Store to 32'h0000_1004, then MAX_CYCLES reached → no early stop; timeout path taken.
- Tohost store on the same edge the budget expires → `pass`=1, `timeout`=0.
- `start` re-asserted in DONE → flags and counters clear, RESET entered, second run completes normally.
- `start` held high during RUN → no restart.
